// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word plus the instruction cache address split,
// frame layout and controller states.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    localparam int IIDX_W = 4;
    localparam int ITAG_W = WORD_W - 2 - IIDX_W;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache between the fetch stage and memory control.
// Hits answer in the same cycle; a miss parks in FETCH until memory drops iwait.
module icache
    import cpu_types_pkg::*;
#(
    parameter int IDX_W = IIDX_W
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          imemREN,
    input  word_t         imemaddr,
    output logic          ihit,
    output word_t         imemload,
    output logic          iREN,
    output word_t         iaddr,
    input  logic          iwait,
    input  word_t         iload,
    output icache_state_t o_dbg_state
);

    localparam int NFRAMES = 2 ** IDX_W;

    icache_frame_t r_frames [NFRAMES];
    icache_state_t r_state;
    icache_state_t w_state_next;
    icachef_t      r_miss;
    icachef_t      w_req;
    icache_frame_t w_frame;
    logic          w_hit;
    logic          w_latch_miss;
    logic          w_fill;
    logic          w_unused_bytoff;

    assign w_req           = icachef_t'(imemaddr);
    assign w_frame         = r_frames[w_req.idx];
    assign w_hit           = imemREN && w_frame.valid && (w_frame.tag == w_req.tag);
    assign w_unused_bytoff = ^w_req.bytoff;
    assign o_dbg_state     = r_state;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Miss address is word aligned so iaddr never carries byte offset bits.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_miss <= '0;
        end else if (w_latch_miss) begin
            r_miss <= '{tag: w_req.tag, idx: w_req.idx, bytoff: 2'b00};
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NFRAMES; i++) begin
                r_frames[i] <= '0;
            end
        end else if (w_fill) begin
            r_frames[r_miss.idx] <= '{valid: 1'b1, tag: r_miss.tag, data: iload};
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch_miss = 1'b0;
        w_fill       = 1'b0;
        ihit         = 1'b0;
        imemload     = '0;
        iREN         = 1'b0;
        iaddr        = '0;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    ihit     = 1'b1;
                    imemload = w_frame.data;
                end else if (imemREN) begin
                    w_latch_miss = 1'b1;
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                // The fill targets the latched miss, whatever the datapath presents now.
                iREN  = 1'b1;
                iaddr = r_miss;
                if (!iwait) begin
                    w_fill       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache.sv
// Randomised bench for icache: a memory responder with chosen latencies and a
// word-level cache model predict every ihit word, miss latency and fetch address.
module tb_icache;
    import cpu_types_pkg::*;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          imemREN;
    logic [31:0]   imemaddr;
    logic          ihit;
    logic [31:0]   imemload;
    logic          iREN;
    logic [31:0]   iaddr;
    logic          iwait;
    logic [31:0]   iload;
    icache_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_iaddr_q[$];
    int          wait_q[$];
    logic [31:0] mem_ov [logic [31:0]];

    bit          m_valid [16];
    logic [31:0] m_addr  [16];

    icache dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .o_dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

    function automatic int frame_of(input logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[frame_of(a)] && (m_addr[frame_of(a)] == word_of(a));
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        m_valid[frame_of(a)] = 1'b1;
        m_addr[frame_of(a)]  = word_of(a);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_addr[i]  = '0;
        end
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        logic [31:0] w;
        w = word_of(a);
        if (mem_ov.exists(w)) return mem_ov[w];
        return (w * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Memory responder: each fetch takes the next scripted wait count and fetch address.
    initial begin
        int          cnt;
        bit          active;
        logic [31:0] cur;
        cnt = 0;
        active = 1'b0;
        cur = '0;
        iwait = 1'b1;
        iload = '0;
        forever begin
            @(negedge CLK);
            if (!iREN) begin
                active = 1'b0;
                iwait  = 1'b1;
                iload  = '0;
            end else begin
                if (!active) begin
                    active = 1'b1;
                    if (wait_q.size() == 0 || exp_iaddr_q.size() == 0) begin
                        check("fetch_unexpected", 32'd1, 32'd0);
                        cnt = 0;
                        cur = iaddr;
                    end else begin
                        cnt = wait_q.pop_front();
                        cur = exp_iaddr_q.pop_front();
                    end
                end
                check("iaddr", iaddr, cur);
                if (cnt > 0) begin
                    iwait = 1'b1;
                    cnt--;
                end else begin
                    iwait  = 1'b0;
                    iload  = mem_read(iaddr);
                    active = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every ihit must match the oldest expected word.
    initial begin
        forever begin
            @(negedge CLK);
            if (nRST) begin
                if (ihit) begin
                    if (exp_q.size() == 0) check("ihit_unexpected", 32'd1, 32'd0);
                    else check("imemload", imemload, exp_q.pop_front());
                end else begin
                    check("imemload_no_hit", imemload, 32'd0);
                end
                if (iREN) check("ihit_in_fetch", {31'd0, ihit}, 32'd0);
                else check("iaddr_not_fetch", iaddr, 32'd0);
            end
        end
    end

    // One fetch: request a; if chg, swap imemaddr to b the cycle after a misses.
    task automatic request(input logic [31:0] a, input int wa, input bit chg, input logic [31:0] b);
        int          lat;
        int          wb;
        int          k;
        logic [31:0] f;
        f = a;
        if (model_hit(a)) begin
            lat = 0;
        end else begin
            wait_q.push_back(wa);
            exp_iaddr_q.push_back(word_of(a));
            model_fill(a);
            lat = wa + 2;
            if (chg) begin
                f = b;
                if (!model_hit(b)) begin
                    wb = $urandom_range(0, 3);
                    wait_q.push_back(wb);
                    exp_iaddr_q.push_back(word_of(b));
                    model_fill(b);
                    lat += wb + 2;
                end
            end
        end
        exp_q.push_back(mem_read(f));
        imemREN  = 1'b1;
        imemaddr = a;
        k = 0;
        forever begin
            @(negedge CLK);
            if (ihit) break;
            if (k >= 60) begin
                check("request_timeout", 32'(k), 32'(lat));
                break;
            end
            @(posedge CLK);
            #1;
            if (chg && k == 0) imemaddr = b;
            k++;
        end
        check("latency", 32'(k), 32'(lat));
        if (lat == 0) check("hit_no_iren", {31'd0, iREN}, 32'd0);
        @(posedge CLK);
        #1;
        imemREN = 1'b0;
    endtask

    initial begin
        model_clear();
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ihit", {31'd0, ihit}, 32'd0);
        check("rst_imemload", imemload, 32'd0);
        check("rst_iren", {31'd0, iREN}, 32'd0);
        check("rst_iaddr", iaddr, 32'd0);
        check("rst_state", {31'd0, dbg_state}, {31'd0, IDLE});
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        mem_ov[32'h0000_0000] = 32'h2002_0001;
        mem_ov[32'h0000_0004] = 32'hAAAA_AAAA;
        mem_ov[32'h0000_0044] = 32'hBBBB_BBBB;

        request(32'h0000_0000, 3, 1'b0, '0);
        request(32'h0000_0000, 0, 1'b0, '0);
        request(32'h0000_0004, 1, 1'b0, '0);
        request(32'h0000_0044, 2, 1'b0, '0);
        request(32'h0000_0004, 0, 1'b0, '0);
        request(32'h0000_0007, 0, 1'b0, '0);
        request(32'h0000_0100, 2, 1'b1, 32'h0000_0200);
        request(32'h0000_0200, 0, 1'b0, '0);
        request(32'h0000_0100, 1, 1'b0, '0);
        request(32'h0000_0000, 1, 1'b0, '0);
        request(32'h0000_0000, 0, 1'b0, '0);

        // Async reset while a fetch is stalled on memory.
        wait_q.push_back(8);
        exp_iaddr_q.push_back(32'h1000_0008);
        imemREN  = 1'b1;
        imemaddr = 32'h1000_0008;
        @(posedge CLK);
        #2;
        check("fetch_entered", {31'd0, iREN}, 32'd1);
        nRST = 1'b0;
        #1;
        check("arst_iren", {31'd0, iREN}, 32'd0);
        check("arst_ihit", {31'd0, ihit}, 32'd0);
        check("arst_iaddr", iaddr, 32'd0);
        wait_q.delete();
        exp_iaddr_q.delete();
        exp_q.delete();
        model_clear();
        imemREN = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        request(32'h0000_0000, 1, 1'b0, '0);

        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            bit          chg;
            a   = 32'($urandom_range(0, 255));
            b   = 32'($urandom_range(0, 255));
            chg = !model_hit(a) && ($urandom_range(0, 3) == 0);
            request(a, int'($urandom_range(0, 4)), chg, b);
            if ($urandom_range(0, 3) == 0) begin
                imemaddr = 32'($urandom);
                repeat ($urandom_range(1, 3)) @(posedge CLK);
                #1;
            end
        end

        repeat (4) @(posedge CLK);
        #1;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("fetch_q_drained", 32'(wait_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache: responder on the instruction half of datapath_cache_if, serving imemREN/imemaddr with ihit/imemload.
- Initiator toward the memory controller over the instruction channel of caches_if (iREN/iaddr out, iwait/iload in).
- Sits between the datapath fetch stage and memory control.
- The data-side signals (dmemREN/dmemWEN/dhit/dmemload) are not handled here.

Parameters:
- IDX_W, 4: index width; number of frames = 2**IDX_W (16). Tag width = 30 - IDX_W.

Ports:
- CLK  input  1  clock; all state updates on rising edge
- nRST  input  1  asynchronous active-low reset
- imemREN  input  1  datapath instruction read request
- imemaddr  input  32  instruction byte address; bits [1:0] ignored
- ihit  output  1  requested word valid on imemload this cycle
- imemload  output  32  instruction word; 0 when ihit=0
- iREN  output  1  memory read request
- iaddr  output  32  memory word address
- iwait  input  1  memory busy; low = iload valid this cycle
- iload  input  32  memory read data

Behaviour:
- Address split: tag = addr[31:IDX_W+2], idx = addr[IDX_W+1:2], byte offset addr[1:0] ignored.
- Frame storage, per frame: valid(1), tag, data(32). On reset all valid bits are cleared; tag and data are don't-care but reset to 0.
- FSM states: IDLE, FETCH.
- IDLE:
  - hit = imemREN && frame[idx].valid && frame[idx].tag == tag.
  - On hit, ihit=1 and imemload=frame[idx].data combinationally, in the same cycle (zero-latency hit).
  - On imemREN && !hit: latch {imemaddr[31:2],2'b00} into miss_addr and go to FETCH next cycle. ihit=0 during the miss cycle.
  - With imemREN=0: ihit=0, iREN=0, no state change.
- FETCH:
  - iREN=1, iaddr=miss_addr, ihit=0.
  - When iwait=0: write frame[miss_idx] = {1, miss_tag, iload` }. Go to IDLE.
  - Fill-to-hit latency: the next cycle re-evaluates the hit in IDLE. Minimum miss latency = 1 (detect) + N (memory) + 1 (hit) cycles.
  - While iwait=1, remain in FETCH holding iREN and iaddr stable.
- Address change mid-miss (imemaddr changes or imemREN drops during FETCH):
  - The fetch still completes and fills miss_addr's frame.
  - On return to IDLE, the current request is evaluated fresh and may miss again.
- Eviction: a fill overwrites the frame unconditionally. There is no dirty state; the cache is read-only.
- ihit is never asserted in FETCH, even if the current imemaddr hits a different frame. The datapath PC advances only on ihit.
- Reset asserted mid-FETCH: iREN drops immediately (async), state = IDLE, all valid bits cleared. A late iload is ignored.
- Reset values of outputs: ihit=0, imemload=0, iREN=0, iaddr=0.
- iaddr = 0 whenever state is not FETCH.
- Memory arbitration against dcache requests is memory control's job; icache only observes iwait.

Decomposition:
- Add to cpu_types_pkg:
  - icachef_t: packed address split {tag, idx, bytoff}.
  - icache_frame_t: packed struct {valid, tag, data}.
  - icache_state_t: enum {IDLE, FETCH}.
- ITAG_W and IIDX_W localparams are derived in the package alongside word_t.
- No sub-module: frame array, FSM and hit compare live in one module. Frame array is a flop array (16x59b), not an SRAM macro.

Test Plan:
- Reset, then imemREN=1, imemaddr=0x0000_0000: ihit=0 cycle 0; FETCH with iREN=1, iaddr=0x0. Memory holds iwait=1 for 3 cycles, then iload=0x2002_0001. Required: ihit=1 and imemload=0x2002_0001 exactly one cycle after the iwait=0 cycle.
- Re-request 0x0000_0000 after fill -> ihit=1 same cycle, iREN stays 0.
- Conflict: fill 0x0000_0004 (idx 1) with 0xAAAA_AAAA, then request 0x0000_0044 (same idx, different tag) -> miss, iaddr=0x44. Fill with 0xBBBB_BBBB. A subsequent request to 0x04 misses again, proving eviction.
- Byte offset: request 0x0000_0007 after 0x04 is cached -> hit, imemload = the 0x04 word.
- Address change mid-miss: miss on 0x100; during FETCH drive imemaddr=0x200. iaddr must stay 0x100 and frame idx 0 fills with tag of 0x100. Next cycle request 0x200 misses with iaddr=0x200.
- Async reset during FETCH (iwait=1): iREN and ihit go 0 before the next edge. After release, request of the previously cached 0x0 misses (valid cleared).
